// File: rtl/if_stage.sv
// Instruction-fetch stage of the PEARL_V core.
// Owns the PC, drives the combinational instruction-memory address and
// registers the returned word with its PC into the IF/ID register.
// Optional feature macro: IF_ALIGN_CHK_EN (misaligned redirect targets are
// reported as a flagged NOP instead of being silently aligned).
module if_stage #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        halt_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  input  logic        id_ready_i,
  output logic        misalign_o
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        valid_q, valid_d;
  logic        xfer;
`ifdef IF_ALIGN_CHK_EN
  logic        mis_q, mis_d;
`endif

  assign imem_addr_o = pc_q;
  assign instr_o     = instr_q;
  assign pc_o        = out_pc_q;
  assign valid_o     = valid_q;
  assign xfer        = !valid_q || id_ready_i;
`ifdef IF_ALIGN_CHK_EN
  assign misalign_o  = mis_q && valid_q;
`else
  assign misalign_o  = 1'b0;
`endif

  // Next-state logic: a redirect always pulls the fetch unit back into RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_i && !redirect_i) state_d = HALT;
      HALT:    if (!halt_i || redirect_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Datapath next values: redirect beats stall, stall beats fetch.
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    out_pc_d = out_pc_q;
    valid_d  = valid_q;
`ifdef IF_ALIGN_CHK_EN
    mis_d    = mis_q;
`endif
    if (redirect_i) begin
`ifdef IF_ALIGN_CHK_EN
      pc_d    = redirect_pc_i;
      mis_d   = 1'b0;
`else
      pc_d    = redirect_pc_i & 32'hFFFF_FFFC;
`endif
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
`ifdef IF_ALIGN_CHK_EN
    // A reported misaligned fetch parks the stage until the trap redirect.
    else if (mis_q) begin
      pc_d = pc_q;
    end
`endif
    else if (xfer) begin
      if (state_q == RUN) begin
`ifdef IF_ALIGN_CHK_EN
        if (pc_q[1:0] != 2'b00) begin
          instr_d  = NOP_INSTR;
          out_pc_d = pc_q;
          valid_d  = 1'b1;
          mis_d    = 1'b1;
        end else begin
          instr_d  = imem_rdata_i;
          out_pc_d = pc_q;
          valid_d  = 1'b1;
          pc_d     = pc_q + 32'd4;
        end
`else
        instr_d  = imem_rdata_i;
        out_pc_d = pc_q;
        valid_d  = 1'b1;
        pc_d     = pc_q + 32'd4;
`endif
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // State and IF/ID register update with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= RUN;
      pc_q     <= RESET_VEC;
      instr_q  <= NOP_INSTR;
      out_pc_q <= 32'h0000_0000;
      valid_q  <= 1'b0;
`ifdef IF_ALIGN_CHK_EN
      mis_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      out_pc_q <= out_pc_d;
      valid_q  <= valid_d;
`ifdef IF_ALIGN_CHK_EN
      mis_q    <= mis_d;
`endif
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by random
// traffic, all compared against a transaction-level fetch model.
module tb_if_stage;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halt = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] redir_pc = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        valid;
  logic        rdy = 1'b1;
  logic        mis;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_opc;
  logic        m_valid, m_run, m_mis;
  logic [31:0] hold_addr;

  if_stage #(.RESET_VEC(RV), .NOP_INSTR(NOP)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .halt_i(halt), .redirect_i(redir),
    .redirect_pc_i(redir_pc), .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata),
    .instr_o(instr), .pc_o(pc_out), .valid_o(valid), .id_ready_i(rdy),
    .misalign_o(mis)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: what decode should see after one clock, from the fetch rules.
  task automatic model_edge(input logic r, input logic h, input logic rd,
                            input logic [31:0] rp, input logic ry);
    if (!r) begin
      m_pc = RV; m_valid = 0; m_instr = NOP; m_opc = 0; m_run = 1; m_mis = 0;
    end else if (rd) begin
`ifdef IF_ALIGN_CHK_EN
      m_pc = rp;
`else
      m_pc = (rp / 4) * 4;
`endif
      m_valid = 0; m_instr = NOP; m_run = 1; m_mis = 0;
    end else begin
      if (!m_mis && (!m_valid || ry)) begin
        if (m_run) begin
          m_opc = m_pc; m_valid = 1;
`ifdef IF_ALIGN_CHK_EN
          if (m_pc % 4 != 0) begin
            m_instr = NOP; m_mis = 1;
          end else begin
            m_instr = mem_word(m_pc); m_pc = m_pc + 4;
          end
`else
          m_instr = mem_word(m_pc); m_pc = m_pc + 4;
`endif
        end else begin
          m_valid = 0;
        end
      end
      m_run = !h;
    end
  endtask

  task automatic step(input logic r, input logic h, input logic rd,
                      input logic [31:0] rp, input logic ry);
    rst_n = r; halt = h; redir = rd; redir_pc = rp; rdy = ry;
    @(posedge clk);
    model_edge(r, h, rd, rp, ry);
    #1;
    chk("valid", {31'b0, valid}, {31'b0, m_valid});
    chk("pc_o", pc_out, m_opc);
    chk("instr", instr, m_instr);
    chk("addr", imem_addr, m_pc);
    chk("misalign", {31'b0, mis}, {31'b0, m_mis & m_valid});
  endtask

  initial begin
    // Reset
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc_o", pc_out, 32'd0);
    chk("rst_addr", imem_addr, RV);
    // Streaming after release
    step(1, 0, 0, 0, 1);
    chk("first_valid", {31'b0, valid}, 32'd1);
    chk("first_pc", pc_out, 32'd0);
    chk("first_instr", instr, 32'h1000_0000);
    step(1, 0, 0, 0, 1);
    chk("seq_pc4", pc_out, 32'd4);
    step(1, 0, 0, 0, 1);
    chk("seq_pc8", pc_out, 32'd8);
    chk("seq_instr2", instr, 32'h1000_0002);
    // Stall three cycles at pc 8
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0);
      chk("stall_pc", pc_out, 32'd8);
      chk("stall_addr", imem_addr, 32'd12);
    end
    step(1, 0, 0, 0, 1);
    chk("release_pc", pc_out, 32'd12);
    step(1, 0, 0, 0, 1);
    chk("pc16", pc_out, 32'd16);
    // Stalled at 16, redirect to 0x40
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 32'h40, 0);
    chk("redir_squash", {31'b0, valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'h40);
    step(1, 0, 0, 0, 1);
    chk("redir_pc", pc_out, 32'h40);
    step(1, 0, 0, 0, 1);
    // Halt during streaming
    step(1, 1, 0, 0, 1);
    step(1, 1, 0, 0, 1);
    chk("halt_valid", {31'b0, valid}, 32'd0);
    hold_addr = imem_addr;
    step(1, 1, 0, 0, 1);
    chk("halt_addr", imem_addr, hold_addr);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    chk("resume_pc", pc_out, hold_addr);
    // Wrap
    step(1, 0, 1, 32'hFFFF_FFFC, 1);
    step(1, 0, 0, 0, 1);
    chk("wrap_hi", pc_out, 32'hFFFF_FFFC);
    step(1, 0, 0, 0, 1);
    chk("wrap_lo", pc_out, 32'h0);
    // Misaligned redirect
    step(1, 0, 1, 32'h42, 1);
    step(1, 0, 0, 0, 1);
`ifdef IF_ALIGN_CHK_EN
    chk("mis_pc", pc_out, 32'h42);
    chk("mis_flag", {31'b0, mis}, 32'd1);
    chk("mis_instr", instr, NOP);
    step(1, 0, 0, 0, 1);
    chk("mis_hold", {31'b0, valid & mis}, 32'd1);
`else
    chk("mis_pc", pc_out, 32'h40);
    chk("mis_flag", {31'b0, mis}, 32'd0);
`endif
    step(1, 0, 1, 32'h100, 1);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic        r, h, rd, ry;
      logic [31:0] rp;
      r  = ($urandom_range(63) != 0);
      h  = ($urandom_range(7) == 0);
      rd = ($urandom_range(9) == 0);
      rp = $urandom;
      if ($urandom_range(3) != 0) rp = rp & 32'hFFFF_FFFC;
      ry = ($urandom_range(3) != 0);
      step(r, h, rd, rp, ry);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the PEARL_V core.
- Owns the program counter and drives the address of the combinational-read instruction memory.
- Registers the returned word together with its PC into the IF/ID pipeline register.
- Hands the instruction to decode over a valid/ready handshake; accepts redirects (branch, jump, trap, mret) from later stages.

Parameters:
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction word presented on instr_o while the register is empty or flushed (addi x0,x0,0).

Ports:
- clk_i  in  1  core clock; all state updates on rising edge.
- rst_n_i  in  1  synchronous active-low reset.
- halt_i  in  1  stop issuing new fetches; the in-flight instruction is still delivered.
- redirect_i  in  1  redirect request from EX/trap logic; one-cycle pulse.
- redirect_pc_i  in  32  redirect target.
- imem_addr_o  out  32  byte address to instruction memory; equals pc_q combinationally.
- imem_rdata_i  in  32  instruction word from memory, same-cycle combinational.
- instr_o  out  32  registered instruction for decode.
- pc_o  out  32  registered PC of instr_o.
- valid_o  out  1  instr_o/pc_o hold a live instruction.
- id_ready_i  in  1  decode accepts the current instruction this cycle.
- misalign_o  out  1  instruction-address-misaligned flag qualified by valid_o; tied 0 unless the optional feature is compiled in.

Behaviour:
- Reset (rst_n_i=0 at a rising edge): pc_q=RESET_VEC, valid_o=0, instr_o=NOP_INSTR, pc_o=0, misalign_o=0, state=RUN. A reset asserted mid-operation discards everything, including any pending redirect.
- FSM has two states.
  - RUN: fetches are issued.
  - HALT: no fetches are issued.
  - RUN->HALT when halt_i=1 and redirect_i=0.
  - HALT->RUN when halt_i=0, or when redirect_i=1 (a redirect always wins over halt).
- Transfer condition: xfer = !valid_o || id_ready_i.
- Priority per edge: reset > redirect > stall > fetch.
- Redirect (redirect_i=1):
  - pc_q <= redirect_pc_i (alignment handling: see Optional Feature).
  - valid_o <= 0, instr_o <= NOP_INSTR.
  - Applies regardless of id_ready_i; the in-flight instruction is squashed.
- Stall (valid_o=1, id_ready_i=0): pc_q, instr_o, pc_o, valid_o all hold.
- Fetch (RUN, xfer=1, no redirect):
  - instr_o <= imem_rdata_i, pc_o <= pc_q, valid_o <= 1.
  - pc_q <= pc_q + 4, modulo 2^32: 32'hFFFF_FFFC wraps to 0.
- HALT with xfer=1: valid_o <= 0, pc_q holds.
- Latency:
  - Redirect in cycle N: imem_addr_o=target in cycle N+1; valid_o=1 with pc_o=target in cycle N+2.
  - Steady-state throughput: 1 instruction/cycle while id_ready_i=1.
- First valid instruction after reset deassertion at edge E appears in the cycle after edge E+1 (pc_o=RESET_VEC).
- imem_addr_o has no register; the fetch loop must not create a combinational path from imem_rdata_i to imem_addr_o.

Optional Feature:
- Macro: IF_ALIGN_CHK_EN.
- Defined:
  - A redirect with redirect_pc_i[1:0]!=0 loads pc_q unmodified.
  - The next fetch produces valid_o=1, misalign_o=1, pc_o=target, instr_o=NOP_INSTR.
  - pc_q does not advance, and no further fetches occur until the next redirect (trap handler entry).
  - misalign_o clears on the redirect.
- Undefined:
  - pc_q <= {redirect_pc_i[31:2],2'b00}.
  - misalign_o constant 0.

Test Plan:
- Reset release, id_ready_i=1, memory word k = 32'h1000_0000+k -> valid_o rises 2nd cycle, pc_o=0,4,8,... with instr_o=32'h1000_0000,...0001,...0002 back-to-back.
- id_ready_i low 3 cycles while valid_o=1, pc_o=8 -> instr_o/pc_o/imem_addr_o frozen; on release pc_o=12 follows with no bubble or duplicate.
- redirect_i pulse to 32'h0000_0040 while stalled at pc_o=16 -> valid_o=0 next cycle, pc_o=32'h40 two cycles after pulse; pc 16's instruction never accepted.
- halt_i=1 during streaming -> current instruction accepted, valid_o then 0, imem_addr_o constant; halt_i=0 resumes at next sequential PC.
- Redirect to 32'hFFFF_FFFC, id_ready_i=1 -> pc_o=32'hFFFF_FFFC then 32'h0000_0000 (wrap).
- Redirect to 32'h0000_0042: with IF_ALIGN_CHK_EN -> valid_o=1, misalign_o=1, pc_o=32'h42, instr_o=NOP_INSTR, held until next redirect; without -> pc_o=32'h40, misalign_o=0.
